force_accumulator: RTL and testbench

FORCE_ACCUMULATOR -- requirements
Module: force_accumulator

---
 rtl/force_accumulator_pkg.sv | 18 +
 rtl/fp32_add.sv | 107 ++++++++++
 rtl/force_accumulator.sv | 110 +++++++++++
 tb/tb_force_accumulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/force_accumulator_pkg.sv
// Shared widths, bit positions and FSM encoding for the pairwise force accumulator.
package force_accumulator_pkg;

  localparam int FP_W     = 32;
  localparam int VEC_W    = 96;
  localparam int PAIR_W   = 193;
  localparam int DONE_BIT = 192;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_NBR   = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  typedef logic [FP_W-1:0] fp32_t;

  localparam fp32_t FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single-precision adder: round-to-nearest-even,
// subnormal operands and results flushed to signed zero.
module fp32_add
  import force_accumulator_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  logic              sa, sb, sl, ss;
  logic [7:0]        ea, eb, el, es;
  logic [22:0]       fa, fb, fl, fs;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              swap;
  logic [26:0]       ml, ms_al;
  logic [7:0]        ediff;
  logic [4:0]        sh;
  logic [53:0]       ms_wide;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] e_norm, e_fin;
  logic              rnd_up;
  logic [24:0]       m_rnd;
  logic [22:0]       mant_fin;

  assign sa = a[31];
  assign sb = b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  // exponent 0 covers both true zeros and flushed subnormals
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // order operands by magnitude so the subtract path never goes negative
  assign swap = ({eb, fb} > {ea, fa});
  assign sl   = swap ? sb : sa;
  assign ss   = swap ? sa : sb;
  assign el   = swap ? eb : ea;
  assign es   = swap ? ea : eb;
  assign fl   = swap ? fb : fa;
  assign fs   = swap ? fa : fb;

  assign ml      = {1'b1, fl, 3'b000};
  assign ediff   = el - es;
  assign sh      = (ediff > 8'd28) ? 5'd28 : ediff[4:0];
  assign ms_wide = {1'b1, fs, 3'b000, 27'd0} >> sh;
  assign ms_al   = {ms_wide[53:28], ms_wide[27] | (|ms_wide[26:0])};

  assign sum = (sl == ss) ? ({1'b0, ml} + {1'b0, ms_al})
                          : ({1'b0, ml} - {1'b0, ms_al});

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
  end

  always_comb begin
    if (sum[27]) begin
      norm   = {sum[27:2], sum[1] | sum[0]};
      e_norm = $signed({2'b00, el}) + 10'sd1;
    end else begin
      norm   = sum[26:0] << lz;
      e_norm = $signed({2'b00, el}) - $signed({5'd0, lz});
    end
  end

  assign rnd_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign m_rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
  assign e_fin    = m_rnd[24] ? (e_norm + 10'sd1) : e_norm;
  assign mant_fin = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];

  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      y = FP_QNAN;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {sa & sb, 31'd0};
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else if (sum == 28'd0) begin
      y = 32'd0;
    end else if (e_fin <= 10'sd0) begin
      y = {sl, 31'd0};
    end else if (e_fin >= 10'sd255) begin
      y = {sl, 8'hFF, 23'd0};
    end else begin
      y = {sl, e_fin[7:0], mant_fin};
    end
  end

endmodule

// File: rtl/force_accumulator.sv
// Per-slot force cache: accumulates reference/neighbour force pairs, then
// streams every slot out and re-zeroes the cache for the next step.
module force_accumulator
  import force_accumulator_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PAIR_W-1:0] in,
  input  logic [ADDR_W-1:0] in_ref_addr,
  input  logic [ADDR_W-1:0] in_nbr_addr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [VEC_W-1:0]  out,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, rptr_reg, nbr_addr_reg;
  logic [VEC_W-1:0]  nbr_force_reg;
  logic [VEC_W-1:0]  mem [DEPTH];

  logic              in_fire, out_fire, is_done, in_nbr;
  logic [ADDR_W-1:0] upd_addr;
  logic [VEC_W-1:0]  upd_old, upd_force, upd_sum;

  assign in_ready  = (state_reg == ST_ACCUM);
  assign in_fire   = in_valid && in_ready;
  assign is_done   = in[DONE_BIT];
  assign out_valid = (state_reg == ST_READ);
  assign out_fire  = out_valid && out_ready;
  assign out       = out_valid ? mem[rptr_reg] : '0;
  assign out_addr  = out_valid ? rptr_reg : '0;
  assign out_last  = out_valid && (rptr_reg == LAST_ADDR);
  assign busy      = (state_reg != ST_ACCUM);

  // one adder bank serves both halves of a pair on alternate cycles
  assign in_nbr    = (state_reg == ST_NBR);
  assign upd_addr  = in_nbr ? nbr_addr_reg : in_ref_addr;
  assign upd_force = in_nbr ? nbr_force_reg : in[VEC_W-1:0];
  assign upd_old   = mem[upd_addr];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      fp32_add u_add (
        .a (upd_old[gi*FP_W +: FP_W]),
        .b (upd_force[gi*FP_W +: FP_W]),
        .y (upd_sum[gi*FP_W +: FP_W])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (clr_ptr_reg == LAST_ADDR) state_next = ST_ACCUM;
      ST_ACCUM: if (in_fire) state_next = is_done ? ST_READ : ST_NBR;
      ST_NBR:   state_next = ST_ACCUM;
      ST_READ:  if (out_fire && out_last) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_CLEAR;
      clr_ptr_reg   <= '0;
      rptr_reg      <= '0;
      nbr_addr_reg  <= '0;
      nbr_force_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_CLEAR) begin
        clr_ptr_reg <= clr_ptr_reg + 1'b1;
      end
      if (in_fire && is_done) begin
        rptr_reg <= '0;
      end else if (out_fire) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      if (out_fire && out_last) begin
        clr_ptr_reg <= '0;
      end
      if (in_fire && !is_done) begin
        nbr_addr_reg  <= in_nbr_addr;
        nbr_force_reg <= in[2*VEC_W-1:VEC_W];
      end
    end
  end

  // cache contents are not reset; CLEAR rewrites every slot before use
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == ST_CLEAR) begin
        mem[clr_ptr_reg] <= '0;
      end else if ((in_fire && !is_done) || in_nbr) begin
        mem[upd_addr] <= upd_sum;
      end
    end
  end

endmodule

// File: tb/tb_force_accumulator.sv
// Scoreboard bench for force_accumulator: pairs are driven, the expected cache
// image is queued per slot and compared as READ streams each slot out.
module tb_force_accumulator;
  import force_accumulator_pkg::*;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [PAIR_W-1:0] in = '0;
  logic [ADDR_W-1:0] in_ref_addr = '0;
  logic [ADDR_W-1:0] in_nbr_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [VEC_W-1:0]  out;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;

  force_accumulator #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ref_addr (in_ref_addr),
    .in_nbr_addr (in_nbr_addr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .out_addr    (out_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [VEC_W-1:0]  data;
    logic              last;
  } exp_t;

  exp_t             sb_q[$];
  logic [VEC_W-1:0] exp_mem [DEPTH];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [VEC_W-1:0] vec(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check_val(tag, n, 256);
    check_val({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out", out, 0);
    check_val("rst_out_addr", out_addr, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_busy", busy, 1);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    reset = 1'b0;
    wait_clear("rst_clear_cycles");
  endtask

  task automatic send_pair(input int r, input int nb, input logic [VEC_W-1:0] rf,
                           input logic [VEC_W-1:0] nf, input bit keep);
    int n = 0;
    in          = {1'b0, nf, rf};
    in_ref_addr = ADDR_W'(r);
    in_nbr_addr = ADDR_W'(nb);
    in_valid    = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check_val("pair_accept", in_ready, 1);
    step();
    $display("pair ref=%0d nbr=%0d ref_f=%h nbr_f=%h", r, nb, rf, nf);
    check_val("nbr_in_ready", in_ready, 0);
    check_val("nbr_busy", busy, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic read_all(input string tag, input bit stall, input bit stray);
    int               cyc = 0;
    bit               held = 0;
    logic [ADDR_W-1:0] h_addr = '0;
    logic [VEC_W-1:0]  h_data = '0;
    exp_t              e;
    in           = '0;
    in[DONE_BIT] = 1'b1;
    in_valid     = 1'b1;
    while (!in_ready && cyc < 100) begin
      step();
      cyc++;
    end
    step();
    in_valid = 1'b0;
    $display("done %s", tag);
    check_val({tag, "_out_valid"}, out_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      sb_q.push_back('{addr: ADDR_W'(i), data: exp_mem[i], last: (i == DEPTH - 1)});
    end
    if (stray) begin
      // a pair offered during READ must be ignored
      in          = {1'b0, vec(32'h3F800000, 0, 0), vec(32'h3F800000, 0, 0)};
      in_ref_addr = 8'd20;
      in_nbr_addr = 8'd21;
      in_valid    = 1'b1;
    end
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 3000) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (held) begin
        check_val({tag, "_hold_addr"}, out_addr, h_addr);
        check_val({tag, "_hold_data"}, out, h_data);
      end
      if (out_valid && out_ready) begin
        e = sb_q.pop_front();
        check_val({tag, "_addr"}, out_addr, e.addr);
        check_val({tag, "_data"}, out, e.data);
        check_val({tag, "_last"}, out_last, e.last);
        $display("read %s slot=%0d data=%h last=%0b", tag, out_addr, out, out_last);
        held = 0;
      end else if (out_valid) begin
        held   = 1;
        h_addr = out_addr;
        h_data = out;
      end
      step();
      cyc++;
    end
    check_val({tag, "_drained"}, sb_q.size(), 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    wait_clear({tag, "_clear_cycles"});
  endtask

  initial begin
    // reset, CLEAR length, empty readout
    apply_reset();
    read_all("empty", 0, 0);

    // single pair with equal and opposite forces
    send_pair(3, 7, vec(32'h3F800000, 32'h40000000, 32'hBF800000),
                    vec(32'hBF800000, 32'hC0000000, 32'h3F800000), 0);
    exp_mem[3] = vec(32'h3F800000, 32'h40000000, 32'hBF800000);
    exp_mem[7] = vec(32'hBF800000, 32'hC0000000, 32'h3F800000);
    read_all("pair", 0, 0);

    // back-to-back pairs onto the same reference slot
    send_pair(5, 6, vec(32'h3F000000, 0, 0), '0, 1);
    send_pair(5, 6, vec(32'h3F000000, 0, 0), '0, 0);
    exp_mem[5] = vec(32'h3F800000, 0, 0);
    read_all("b2b", 0, 0);

    // self pair cancels to +0; rounding and flush boundaries; stalled readout
    send_pair(9, 9, vec(32'h3F800000, 0, 0), vec(32'hBF800000, 0, 0), 0);
    send_pair(10, 11, vec(32'h3F800000, 0, 0), vec(32'h00400000, 0, 0), 0);
    send_pair(10, 12, vec(32'h33800000, 0, 0), vec(32'h80000000, 0, 0), 0);
    send_pair(10, 12, vec(32'h34000000, 0, 0), vec(32'h3F800000, 32'h40400000, 0), 0);
    send_pair(13, 12, '0, vec(32'h3F800000, 32'h3F800000, 0), 0);
    exp_mem[9]  = '0;
    exp_mem[10] = vec(32'h3F800001, 0, 0);
    exp_mem[11] = '0;
    exp_mem[12] = vec(32'h40000000, 32'h40800000, 0);
    read_all("stall", 1, 1);

    // reset while the neighbour half is pending
    in          = {1'b0, vec(32'h3F800000, 0, 0), vec(32'h40000000, 32'h40000000, 32'h40000000)};
    in_ref_addr = 8'd2;
    in_nbr_addr = 8'd4;
    in_valid    = 1'b1;
    step();
    check_val("nbr_state_ready", in_ready, 0);
    apply_reset();
    read_all("after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
